// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - shared encodings for the timer: FSM states, register map, CTRL fields
package timer_dev_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } timer_state_e;

   // Word addresses (bus addr[3:2]); the cpu-side bridge decodes with these too
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_UNUSED = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;
   localparam int CTRL_W       = 4;

   localparam logic [1:0] MODE_ONESHOT    = 2'b00;
   localparam logic [1:0] MODE_AUTORELOAD = 2'b01;

   // Codes 10/11 behave as one-shot, so only 01 selects reload
   function automatic logic mode_is_reload(input logic [1:0] mode);
      return mode == MODE_AUTORELOAD;
   endfunction

endpackage

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - programmable down-counter with one-shot / auto-reload modes and maskable irq
module timer_dev
   import timer_dev_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   timer_state_e      state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [31:0]       preset_q, preset_d;
   logic [31:0]       count_q, count_d;
   logic              pending_q, pending_d;

   logic ctrl_en;
   logic wr_ctrl;
   logic wr_preset;

   assign ctrl_en   = ctrl_q[CTRL_EN];
   assign wr_ctrl   = we && (addr == ADDR_CTRL);
   assign wr_preset = we && (addr == ADDR_PRESET);

   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      preset_d  = preset_q;
      count_d   = count_q;
      pending_d = pending_q;

      case (state_q)
         ST_IDLE: begin
            if (ctrl_en) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_en) begin
               state_d = ST_IDLE;
            end else if (count_q != 32'd0) begin
               count_d = count_q - 32'd1;
            end else begin
               state_d   = ST_INT;
               pending_d = 1'b1;
            end
         end
         ST_INT: begin
            if (mode_is_reload(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO])) begin
               pending_d = 1'b0;
               state_d   = ST_LOAD;
            end else begin
               ctrl_d[CTRL_EN] = 1'b0;
               state_d         = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Bus writes come last so they override the FSM's own CTRL/pending updates
      if (wr_ctrl) begin
         ctrl_d    = din[CTRL_W-1:0];
         pending_d = 1'b0;
      end
      if (wr_preset) begin
         preset_d  = din;
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         ctrl_q    <= '0;
         preset_q  <= '0;
         count_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         preset_q  <= preset_d;
         count_q   <= count_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      dout = 32'd0;
      case (addr)
         ADDR_CTRL:   dout = {{(32-CTRL_W){1'b0}}, ctrl_q};
         ADDR_PRESET: dout = preset_q;
         ADDR_COUNT:  dout = count_q;
         ADDR_UNUSED: dout = 32'd0;
         default:     dout = 32'd0;
      endcase
   end

   assign irq = pending_q & ctrl_q[CTRL_IM];

endmodule
